reg_wr_arbiter: RTL and testbench
=================================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register-bank write port (2..8).
REQ-002 Parameter N_REG, default 8, number of registers in the bank, power of 2 and at least 2.
REQ-003 Parameter DATA_W, default 32, signed data width written to each register.
REQ-004 Port clk  input  1  single clock; all logic on posedge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port req_valid  input  N_REQ  per-requester write request.
REQ-007 Port req_ready  output  N_REQ  per-requester accept; transfer occurs when valid & ready.
REQ-008 Port req_addr  input  N_REQ*$clog2(N_REG)  packed target register index; requester i occupies slice i.
REQ-009 Port req_data  input  N_REQ*DATA_W  packed write data; requester i occupies slice i.
REQ-010 Port req_lock  input  N_REQ  burst-hold request; used only under REQ-024.
REQ-011 Port wr_en  output  N_REG  one-hot write enable, bit k drives the w_en input of register k.
REQ-012 Port wr_data  output  DATA_W  data broadcast to every register's A input.
REQ-013 Port grant_id  output  $clog2(N_REQ)  index of the requester whose write is on wr_en/wr_data.
REQ-014 Port busy  output  1  high while a lock is held.

Function
REQ-015 At most one req_ready bit is high in any cycle; req_ready is combinational from req_valid, the round-robin pointer and the FSM state.
REQ-016 Arbitration is round-robin: the search starts at requester (last_grant+1) mod N_REQ and wraps; after reset, last_grant = N_REQ-1, so requester 0 has first priority.
REQ-017 An accepted transfer is registered: wr_en, wr_data and grant_id present it exactly 1 cycle after the handshake; wr_en is all-zero in every other cycle.
REQ-018 One write is issued per cycle at most; back-to-back handshakes produce back-to-back wr_en pulses.
REQ-019 last_grant updates only on a completed handshake, never on an idle cycle.
REQ-020 wr_en bit = decoded req_addr of the winner; no address range check is needed because N_REG is a power of 2.
REQ-021 FSM states: IDLE (normal round-robin) and LOCK (REQ-024); IDLE is the only state without REQ-024.
REQ-022 A requester that deasserts req_valid without ready loses nothing; no request state is stored.

Reset
REQ-023 While rst is high: wr_en = 0, wr_data = 0, grant_id = 0, busy = 0, req_ready = 0, last_grant = N_REQ-1, state = IDLE; reset mid-lock drops the lock immediately.

Configuration
REQ-024 Macro REG_ARB_LOCK_EN: when defined, a handshake with req_lock[i]=1 moves IDLE->LOCK, busy=1, and only requester i may be granted; LOCK->IDLE on the first handshake from i with req_lock[i]=0, which is itself accepted and written.
REQ-025 When REG_ARB_LOCK_EN is undefined, req_lock is ignored, busy is tied 0 and the LOCK state is not synthesized.

Structure
REQ-026 Package reg_arb_pkg holds the FSM state enum (ARB_IDLE, ARB_LOCK) and the width helpers for the address and grant-id fields.
REQ-027 Sub-module rr_pick (round-robin priority picker: valid vector plus pointer in, one-hot grant out) is instantiated once.

Verification
REQ-028 Reset release, all req_valid=0 -> wr_en=0, req_ready=0 indefinitely.
REQ-029 req_valid=4'b1111, addr 0..3, data 10,20,30,40 -> grants 0,1,2,3,0 in consecutive cycles; wr_en 8'h01,8'h02,8'h04,8'h08 one cycle after each handshake.
REQ-030 Only requester 2 valid with addr 7 and data -5 -> wr_en=8'h80, wr_data=-5 (two's complement), grant_id=2 the next cycle.
REQ-031 Lock (macro on): req 1 locks, reqs 0 and 3 also valid -> only req 1 granted for 3 beats, busy=1; on the unlock beat, busy falls and the next grant goes to 3, then 0.
REQ-032 Assert rst during LOCK with a write pending -> wr_en=0 and busy=0 that cycle; after release, requester 0 is granted first.
REQ-033 Macro off, req_lock=all ones -> behaviour identical to REQ-029, busy=0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and width helpers for the register-bank write arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_arb_pkg;

  // Arbiter FSM states; ARB_LOCK only reachable when REG_ARB_LOCK_EN is defined
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Width of a register-index field (at least one bit)
  function automatic int unsigned addr_w(input int unsigned n_reg);
    return (n_reg < 2) ? 1 : $clog2(n_reg);
  endfunction

  // Width of a requester-id field (at least one bit)
  function automatic int unsigned id_w(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Round-robin picker: first valid requester strictly after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            valid_i,
  input  logic [id_w(N)-1:0]      ptr_i,
  output logic [N-1:0]            grant_o,
  output logic [id_w(N)-1:0]      grant_id_o,
  output logic                    any_o
);

  localparam int IDW = id_w(N);

  logic [IDW-1:0] idx;

  // Scan offsets 1..N from the pointer; the first valid slot wins
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(32'(ptr_i)) + k) % N);
      if (!any_o && valid_i[idx]) begin
        any_o       = 1'b1;
        grant_o     = '0;
        grant_o[idx] = 1'b1;
        grant_id_o  = idx;
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing one register-bank write port; optional burst lock via REG_ARB_LOCK_EN.
// Latency: accepted write appears on wr_en/wr_data/grant_id one cycle after the handshake.
// Backpressure: one req_ready at a time, combinational; losers simply keep req_valid asserted.
module reg_wr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int N_REG  = 8,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*addr_w(N_REG)-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  input  logic [N_REQ-1:0]            req_lock,
  output logic [N_REG-1:0]            wr_en,
  output logic [DATA_W-1:0]           wr_data,
  output logic [id_w(N_REQ)-1:0]      grant_id,
  output logic                        busy
);

  localparam int AW  = addr_w(N_REG);
  localparam int IDW = id_w(N_REQ);

  arb_state_e           state_q;
  logic [IDW-1:0]       last_grant_q;
  logic [N_REG-1:0]     wr_en_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [IDW-1:0]       grant_id_q;

  logic [N_REQ-1:0]     lock_mask;
  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     pick_oh;
  logic [IDW-1:0]       pick_id;
  logic                 pick_any;
  logic                 hs;
  logic [AW-1:0]        sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [N_REG-1:0]     wr_en_d;

`ifdef REG_ARB_LOCK_EN
  logic [IDW-1:0]       lock_id_q;
  logic                 busy_q;

  // While locked only the lock owner is eligible
  assign lock_mask = {{(N_REQ-1){1'b0}}, 1'b1} << lock_id_q;
  assign busy      = busy_q;
`else
  logic                 unused_lock;

  // Lock input has no effect in this build
  assign unused_lock = ^req_lock;
  assign lock_mask   = '1;
  assign busy        = 1'b0;
`endif

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .valid_i    (elig),
    .ptr_i      (last_grant_q),
    .grant_o    (pick_oh),
    .grant_id_o (pick_id),
    .any_o      (pick_any)
  );

  // Eligibility, ready, handshake and the winner's decoded write
  always_comb begin
    elig      = (state_q == ARB_LOCK) ? (req_valid & lock_mask) : req_valid;
    req_ready = rst ? '0 : pick_oh;
    hs        = pick_any & ~rst;
    sel_addr  = req_addr[32'(pick_id)*AW +: AW];
    sel_data  = req_data[32'(pick_id)*DATA_W +: DATA_W];
    wr_en_d   = {{(N_REG-1){1'b0}}, 1'b1} << sel_addr;
  end

  // Registered write port, round-robin pointer and lock FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      wr_en_q      <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= '0;
`ifdef REG_ARB_LOCK_EN
      lock_id_q    <= '0;
      busy_q       <= 1'b0;
`endif
    end else begin
      wr_en_q <= '0;
      if (hs) begin
        wr_en_q      <= wr_en_d;
        wr_data_q    <= sel_data;
        grant_id_q   <= pick_id;
        last_grant_q <= pick_id;
      end
`ifdef REG_ARB_LOCK_EN
      case (state_q)
        ARB_IDLE: begin
          if (hs && req_lock[pick_id]) begin
            state_q   <= ARB_LOCK;
            lock_id_q <= pick_id;
            busy_q    <= 1'b1;
          end
        end
        ARB_LOCK: begin
          // The unlocking beat is itself accepted and written
          if (hs && !req_lock[pick_id]) begin
            state_q <= ARB_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
`else
      state_q <= ARB_IDLE;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed steps plus random traffic against a rule-level model.
// Latency: expects each accepted write one cycle after its handshake.
// Backpressure: checks that exactly the model's winner sees req_ready.
module tb_reg_wr_arbiter;

  localparam int N_REQ  = 4;
  localparam int N_REG  = 8;
  localparam int DATA_W = 32;
  localparam int AW     = 3;

`ifdef REG_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*AW-1:0]       req_addr;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          req_lock;
  logic [N_REG-1:0]          wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic [1:0]                grant_id;
  logic                      busy;

  always #5 clk = ~clk;

  reg_wr_arbiter #(
    .N_REQ  (N_REQ),
    .N_REG  (N_REG),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: last granted requester, lock status, expected outputs
  int          m_last;
  bit          m_locked;
  int          m_owner;
  logic [7:0]  e_wr_en;
  logic [31:0] e_data;
  logic [1:0]  e_gid;
  logic        e_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int d, input bit lk);
    logic [AW-1:0] a3;
    a3 = a[AW-1:0];
    req_valid[i]                = v;
    req_addr[i*AW +: AW]         = a3;
    req_data[i*DATA_W +: DATA_W] = d;
    req_lock[i]                 = lk;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_lock  = '0;
  endtask

  task automatic model_reset();
    m_last   = N_REQ - 1;
    m_locked = 1'b0;
    m_owner  = 0;
    e_wr_en  = '0;
    e_data   = '0;
    e_gid    = '0;
    e_busy   = 1'b0;
  endtask

  // One clock: check ready mid-cycle, predict, then check registered outputs after the edge
  task automatic cycle(input string tag);
    int w;
    logic [3:0] elig;
    logic [3:0] exp_ready;
    logic [AW-1:0] wa;
    #3;
    elig = req_valid;
    if (m_locked) elig = req_valid & (4'b0001 << m_owner);
    w = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int c;
      c = (m_last + k) % N_REQ;
      if (w < 0 && elig[c]) w = c;
    end
    exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    chk({tag, ":ready"}, req_ready, exp_ready);
    if (w >= 0) begin
      wa      = req_addr[w*AW +: AW];
      e_wr_en = 8'b0000_0001 << wa;
      e_data  = req_data[w*DATA_W +: DATA_W];
      e_gid   = w[1:0];
      m_last  = w;
      if (LOCK_ON) begin
        if (!m_locked && req_lock[w]) begin
          m_locked = 1'b1;
          m_owner  = w;
        end else if (m_locked && !req_lock[w]) begin
          m_locked = 1'b0;
        end
      end
    end else begin
      e_wr_en = '0;
    end
    e_busy = m_locked;
    @(posedge clk);
    #1;
    chk({tag, ":wr_en"},    wr_en,    e_wr_en);
    chk({tag, ":wr_data"},  wr_data,  e_data);
    chk({tag, ":grant_id"}, grant_id, e_gid);
    chk({tag, ":busy"},     busy,     e_busy);
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    req_valid = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst:wr_en",    wr_en,     8'h00);
    chk("rst:wr_data",  wr_data,   32'h0);
    chk("rst:grant_id", grant_id,  2'd0);
    chk("rst:busy",     busy,      1'b0);
    chk("rst:ready",    req_ready, 4'h0);
    rst = 1'b0;
    clear_reqs();

    // Idle after reset: nothing granted, nothing written
    repeat (4) cycle("idle");

    // All four valid, addr i, data 10..40: grants 0,1,2,3,0; lock held high when the feature is off
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i, 10 * (i + 1), !LOCK_ON);
    repeat (5) cycle("rr");
    chk("rr:last_gid", grant_id, 2'd0);

    // Single requester 2, register 7, negative data
    clear_reqs();
    set_req(2, 1'b1, 7, -5, 1'b0);
    cycle("neg");
    chk("neg:wr_en",    wr_en,    8'h80);
    chk("neg:wr_data",  wr_data,  32'hFFFF_FFFB);
    chk("neg:grant_id", grant_id, 2'd2);
    clear_reqs();
    cycle("neg_after");
    chk("neg_after:wr_en", wr_en, 8'h00);

    // Random traffic with occasional lock requests
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N_REQ; i++)
        set_req(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 7), $urandom,
                ($urandom_range(0, 4) == 0));
      cycle("rand");
    end

    // Release any lock left by the random phase, then park the pointer at requester 0
    clear_reqs();
    if (m_locked) begin
      set_req(m_owner, 1'b1, 0, 1, 1'b0);
      cycle("unlock_prep");
      clear_reqs();
    end
    set_req(0, 1'b1, 1, 111, 1'b0);
    cycle("park0");
    clear_reqs();

`ifdef REG_ARB_LOCK_EN
    // Requester 1 locks for three beats while 0 and 3 wait, then unlocks
    set_req(0, 1'b1, 2, 100, 1'b0);
    set_req(1, 1'b1, 4, 200, 1'b1);
    set_req(3, 1'b1, 6, 300, 1'b0);
    cycle("lock1");
    chk("lock1:gid",  grant_id, 2'd1);
    chk("lock1:busy", busy,     1'b1);
    cycle("lock2");
    cycle("lock3");
    chk("lock3:gid",  grant_id, 2'd1);
    set_req(1, 1'b1, 5, 201, 1'b0);
    cycle("unlock");
    chk("unlock:gid",  grant_id, 2'd1);
    chk("unlock:busy", busy,     1'b0);
    set_req(1, 1'b0, 0, 0, 1'b0);
    cycle("after_unlock_a");
    chk("after_unlock_a:gid", grant_id, 2'd3);
    cycle("after_unlock_b");
    chk("after_unlock_b:gid", grant_id, 2'd0);
    clear_reqs();
`endif

    // Reset while a (possibly locked) burst is in flight
    set_req(2, 1'b1, 5, 77, 1'b1);
    cycle("pre_rst");
    set_req(0, 1'b1, 3, 55, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst:wr_en", wr_en,     8'h00);
    chk("midrst:busy",  busy,      1'b0);
    chk("midrst:ready", req_ready, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 7 - i, 1000 + i, 1'b0);
    cycle("post_rst");
    chk("post_rst:gid",   grant_id, 2'd0);
    chk("post_rst:wr_en", wr_en,    8'h80);
    clear_reqs();
    repeat (2) cycle("tail");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
